// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation sequencer: serves one dry zone at a time (round-robin), timed run,
// rest interval and sticky fault. Per-zone choice between sprinkler pump (Bs) and drip valve (Vs).
module irrigacao_multizona #(
  parameter int N_ZONES     = 4,
  parameter int RUN_CYCLES  = 1000,
  parameter int REST_CYCLES = 100,
  parameter int CNT_W       = 16,
  parameter int ZW          = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               L,
  input  logic [N_ZONES-1:0] Us,
  input  logic               Ua,
  input  logic               T,
  input  logic               M,
  input  logic               ERRO,
  input  logic               err_clr,
  output logic [N_ZONES-1:0] Bs,
  output logic [N_ZONES-1:0] Vs,
  output logic [ZW-1:0]      zona,
  output logic               ativo,
  output logic               falha
);

  typedef enum logic [1:0] {IDLE, RUN, REST, FAULT} state_t;

  state_t             state_reg, state_next;
  logic [ZW-1:0]      zona_reg, zona_next;
  logic [ZW-1:0]      rr_reg, rr_next;
  logic               mode_reg, mode_next;   // 1 = sprinkler, 0 = drip
  logic [CNT_W-1:0]   timer_reg, timer_next;
  logic               wet_reg, wet_next;     // served zone read wet on the previous RUN cycle
  logic [N_ZONES-1:0] bs_reg, bs_next;
  logic [N_ZONES-1:0] vs_reg, vs_next;
  logic               ativo_reg, falha_reg;

  // Round-robin search: rotate the dry mask so the rr pointer lands on bit 0,
  // take the lowest set bit, then rotate the offset back into a zone index.
  logic [2*N_ZONES-1:0] dry2;
  logic [N_ZONES-1:0]   dry_rot;
  logic [ZW-1:0]        pick_off;
  logic [ZW:0]          pick_sum;
  logic [ZW-1:0]        pick_zone;
  logic                 any_dry;
  logic [ZW-1:0]        zona_inc;
  logic [N_ZONES-1:0]   onehot_next;

  assign dry2    = {~Us, ~Us} >> rr_reg;
  assign dry_rot = dry2[N_ZONES-1:0];
  assign any_dry = |dry_rot;

  always_comb begin
    pick_off = '0;
    for (int k = N_ZONES - 1; k >= 0; k--) begin
      if (dry_rot[k]) pick_off = ZW'(k);
    end
  end

  assign pick_sum  = {1'b0, rr_reg} + {1'b0, pick_off};
  assign pick_zone = (pick_sum >= (ZW+1)'(N_ZONES)) ? ZW'(pick_sum - (ZW+1)'(N_ZONES))
                                                     : ZW'(pick_sum);
  assign zona_inc  = (zona_reg == ZW'(N_ZONES - 1)) ? '0 : zona_reg + ZW'(1);

  always_comb begin
    state_next = state_reg;
    zona_next  = zona_reg;
    rr_next    = rr_reg;
    mode_next  = mode_reg;
    timer_next = timer_reg;
    wet_next   = wet_reg;
    if (ERRO) begin
      state_next = FAULT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (L && any_dry) begin
            state_next = RUN;
            zona_next  = pick_zone;
            mode_next  = !Ua || (!T && M);
            timer_next = CNT_W'(RUN_CYCLES - 1);
            wet_next   = 1'b0;
          end
        end
        RUN: begin
          wet_next = Us[zona_reg];
          if (timer_reg == '0 || !L || (Us[zona_reg] && wet_reg)) begin
            state_next = REST;
            rr_next    = zona_inc;
            timer_next = CNT_W'(REST_CYCLES - 1);
          end else begin
            timer_next = timer_reg - CNT_W'(1);
          end
        end
        REST: begin
          if (timer_reg == '0) state_next = IDLE;
          else                 timer_next = timer_reg - CNT_W'(1);
        end
        FAULT: begin
          if (err_clr) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they leave the flops directly.
  always_comb begin
    onehot_next = N_ZONES'(1) << zona_next;
    bs_next     = (state_next == RUN &&  mode_next) ? onehot_next : '0;
    vs_next     = (state_next == RUN && !mode_next) ? onehot_next : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      zona_reg  <= '0;
      rr_reg    <= '0;
      mode_reg  <= 1'b0;
      timer_reg <= '0;
      wet_reg   <= 1'b0;
      bs_reg    <= '0;
      vs_reg    <= '0;
      ativo_reg <= 1'b0;
      falha_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      zona_reg  <= zona_next;
      rr_reg    <= rr_next;
      mode_reg  <= mode_next;
      timer_reg <= timer_next;
      wet_reg   <= wet_next;
      bs_reg    <= bs_next;
      vs_reg    <= vs_next;
      ativo_reg <= (state_next == RUN);
      falha_reg <= (state_next == FAULT);
    end
  end

  assign Bs    = bs_reg;
  assign Vs    = vs_reg;
  assign zona  = zona_reg;
  assign ativo = ativo_reg;
  assign falha = falha_reg;

endmodule
